seq_magnitude_comparator: RTL
=============================

// Module: seq_magnitude_comparator
// PURPOSE
//  Compares two WIDTH-bit unsigned operands two bits per clock, MSB-first.
//  Acts as the originating end of the less/greater/equal cascade: it seeds the
//  chain as (l=0,g=0,e=1), feeds each digit's state into the next, and reports
//  the final relation. Used wherever a wide compare is needed without a wide
//  combinational chain, for example in counters and threshold checks.
// PARAMETERS
//  WIDTH       8  operand width; must be even and >= 2 (N = WIDTH/2 digits)
//  EARLY_EXIT  1  1: finish as soon as lt or gt is decided; 0: always scan all N digits
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request a compare; accepted only when busy==0
//  a      in   WIDTH  operand A; sampled on the accepting edge only
//  b      in   WIDTH  operand B; sampled on the accepting edge only
//  busy   out  1      high while a compare is in progress
//  done   out  1      one-cycle pulse; lt/gt/eq are valid from this cycle on
//  lt     out  1      A < B
//  gt     out  1      A > B
//  eq     out  1      A == B
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, lt=0, gt=0, eq=0; captured operands and cascade cleared.
//  FSM states IDLE and RUN.
//   IDLE: if start, then capture a and b, set idx=N-1, set cascade (l,g,e)=(0,0,1), busy<=1, go to RUN.
//   RUN: each edge evaluates digit idx = {x1,x0}={A[2i+1],A[2i]}, {y1,y0} likewise from B:
//     e' = ~g & ~l & (x==y)
//     l' = ~g & (l | x<y)
//     g' = ~l & (g | x>y)
//    Then decrement idx.
//    Exit after digit 0, or, with EARLY_EXIT=1, on the first edge where l' or g' is 1.
//    On exit: lt<=l', gt<=g', eq<=e', done<=1 for one cycle, busy<=0, go to IDLE.
//  Exactly one of lt/gt/eq is 1 after any done. Results hold until the next done or reset.
//  Latency, with start high in cycle 0:
//   - busy is high in cycles 1..N.
//   - done is high in cycle N+1.
//   - With early exit on digit k (k = MSB-first count, 1-based), busy is high in cycles 1..k and done is high in cycle k+1.
//  start while busy==1 is ignored, with no queuing and no effect on the active compare.
//  start in the done cycle is accepted, which gives back-to-back operation with no dead cycle.
//  a and b may change freely after the accepting edge.
//  rst mid-RUN aborts the compare: return to reset values, and no done pulse is produced.
//  The idx counter is $clog2(N) bits wide, with a minimum of 1. It never wraps below 0, because the exit occurs at idx==0.
// STRUCTURE
//  Shared package: state encoding constants (ST_IDLE, ST_RUN) and the cascade seed constants
//   CASC_SEED_L=0, CASC_SEED_G=0, CASC_SEED_E=1.
//  One sub-module, cmp2_step: purely combinational 2-bit digit step with inputs x[1:0], y[1:0],
//   lin, gin, ein and outputs lout, gout, eout, implementing the equations above.
//   ein is carried for interface symmetry. eout is derived from ~lin & ~gin & (x==y).
//  Top level contains the FSM, the operand registers, the idx counter, the digit mux and the result registers.
// TESTING (WIDTH=8, start pulsed in cycle 0 unless noted)
//  1 a=8'hA5, b=8'hA5 -> busy in cycles 1-4, done in cycle 5, eq=1, lt=0, gt=0.
//  2 a=8'h80, b=8'h7F, EARLY_EXIT=1 -> done in cycle 2, gt=1. With EARLY_EXIT=0 -> done in cycle 5, gt=1.
//  3 a=8'h12, b=8'h13 -> decided on the last digit, done in cycle 5, lt=1.
//  4 start again in cycle 2 with a=8'hFF, b=8'h00 during the compare of test 1 -> ignored; result is eq=1 in cycle 5.
//  5 rst high in cycle 3 of a RUN -> in cycle 4 busy=0 and lt=gt=eq=0, and no done pulse occurs.
//    A following start compares normally.
//  6 Back-to-back: start a=8'h00, b=8'hFF in the done cycle of a prior compare -> busy the next cycle,
//    and the earlier result holds until the new done (lt=1).

Source files
------------

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared constants for the sequential magnitude comparator: FSM encoding and cascade seed.
package seq_magnitude_comparator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Originating end of the less/greater/equal cascade: "equal so far".
  localparam logic CASC_SEED_L = 1'b0;
  localparam logic CASC_SEED_G = 1'b0;
  localparam logic CASC_SEED_E = 1'b1;

endpackage

// File: rtl/seq_magnitude_comparator_cmp2_step.sv
// One 2-bit digit of the MSB-first less/greater/equal cascade (purely combinational).
module cmp2_step (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       lin,
  input  logic       gin,
  input  logic       ein,
  output logic       lout,
  output logic       gout,
  output logic       eout
);

  // ein only keeps the port list symmetric; equality is rebuilt from lin/gin.
  logic unused_ein;
  assign unused_ein = ein;

  // A decided relation from a more significant digit always wins.
  always_comb begin
    eout = ~gin & ~lin & (x == y);
    lout = ~gin & (lin | (x < y));
    gout = ~lin & (gin | (x > y));
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Unsigned WIDTH-bit compare, two bits per clock MSB-first, with optional early exit.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int unsigned N    = WIDTH / 2;
  localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

  state_t               state, state_d;
  logic [N-1:0][1:0]    a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]      idx, idx_d;
  logic                 l_q, l_d, g_q, g_d, e_q, e_d;
  logic                 busy_d, done_d, lt_d, gt_d, eq_d;
  logic [1:0]           x_dig, y_dig;
  logic                 l_nx, g_nx, e_nx;
  logic                 last_c;

  // Digit mux: current digit of each captured operand.
  assign x_dig = a_q[idx];
  assign y_dig = b_q[idx];

  cmp2_step u_step (
    .x    (x_dig),
    .y    (y_dig),
    .lin  (l_q),
    .gin  (g_q),
    .ein  (e_q),
    .lout (l_nx),
    .gout (g_nx),
    .eout (e_nx)
  );

  // Finish after digit 0, or as soon as the relation is decided when early exit is on.
  assign last_c = (idx == '0) || ((EARLY_EXIT != 0) && (l_nx || g_nx));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx;
    l_d     = l_q;
    g_d     = g_q;
    e_d     = e_q;
    busy_d  = busy;
    done_d  = 1'b0;
    lt_d    = lt;
    gt_d    = gt;
    eq_d    = eq;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IDXW'(N - 1);
          l_d     = CASC_SEED_L;
          g_d     = CASC_SEED_G;
          e_d     = CASC_SEED_E;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        l_d = l_nx;
        g_d = g_nx;
        e_d = e_nx;
        if (last_c) begin
          lt_d    = l_nx;
          gt_d    = g_nx;
          eq_d    = e_nx;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          idx_d = IDXW'(idx - 1'b1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand, cascade and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      l_q   <= 1'b0;
      g_q   <= 1'b0;
      e_q   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_d;
      a_q   <= a_d;
      b_q   <= b_d;
      idx   <= idx_d;
      l_q   <= l_d;
      g_q   <= g_d;
      e_q   <= e_d;
      busy  <= busy_d;
      done  <= done_d;
      lt    <= lt_d;
      gt    <= gt_d;
      eq    <= eq_d;
    end
  end

endmodule
